// File: rtl/system_pkg.sv
// Shared definitions for the single-bus datapath: ALU opcodes, IR field
// positions, CON condition codes and the CON evaluation helper.
package system_pkg;

  localparam int WORD_W = 32;
  localparam int MEM_AW = 9;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_NEG  = 5'b10000,
    OP_NOT  = 5'b10001
  } alu_op_t;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C2_LSB = 19;
  localparam int IR_C_MSB  = 18;

  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_POS     = 2'b10,
    C2_NEG     = 2'b11
  } c2_t;

  function automatic logic con_eval(input logic [1:0] c2, input logic [WORD_W-1:0] value);
    logic result;
    case (c2)
      C2_ZERO:    result = (value == '0);
      C2_NONZERO: result = (value != '0);
      C2_POS:     result = ~value[WORD_W-1];
      default:    result = value[WORD_W-1];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/system_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result feeds Z.
// IncPC overrides the opcode so the fetch sequence can bump PC through Z.
module system_alu
  import system_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [4:0]              opcode,
  input  logic                    inc_pc,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] ZERO_W = '0;

  logic [4:0]                   shamt;
  logic [2*DATA_WIDTH-1:0]      rot_r;
  logic [2*DATA_WIDTH-1:0]      rot_l;
  logic [DATA_WIDTH-1:0]        sra_val;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] quot;
  logic signed [DATA_WIDTH-1:0] rem;

  // Rotates shift a doubled copy so the wrapped bits fall out naturally.
  always_comb begin
    shamt   = b[4:0];
    rot_r   = {a, a} >> shamt;
    rot_l   = {a, a} << shamt;
    sra_val = $signed(a) >>> shamt;
    prod    = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
              $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    quot    = '0;
    rem     = '0;
    if (b != '0) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    result = '0;
    if (inc_pc) begin
      result = {ZERO_W, b + DATA_WIDTH'(1)};
    end else begin
      case (opcode)
        OP_ADD:  result = {ZERO_W, a + b};
        OP_SUB:  result = {ZERO_W, a - b};
        OP_SHR:  result = {ZERO_W, a >> shamt};
        OP_SHRA: result = {ZERO_W, sra_val};
        OP_SHL:  result = {ZERO_W, a << shamt};
        OP_ROR:  result = {ZERO_W, rot_r[DATA_WIDTH-1:0]};
        OP_ROL:  result = {ZERO_W, rot_l[2*DATA_WIDTH-1:DATA_WIDTH]};
        OP_AND:  result = {ZERO_W, a & b};
        OP_OR:   result = {ZERO_W, a | b};
        OP_MUL:  result = prod;
        OP_DIV:  result = {rem, quot};
        OP_NEG:  result = {ZERO_W, ZERO_W - b};
        OP_NOT:  result = {ZERO_W, ~b};
        default: result = {ZERO_W, b};
      endcase
    end
  end

endmodule

// File: rtl/system.sv
// Single-bus 32-bit datapath with register file, special registers, ALU and a
// 512x32 memory; every transfer is steered by externally supplied controls.
module system
  import system_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = MEM_AW
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  input  logic                  outport_in,
  output logic [DATA_WIDTH-1:0] outport_data,
  output logic                  con_ff_bit,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  output logic                  memory_done
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   rf_reg [16];
  logic [DATA_WIDTH-1:0]   pc_reg;
  logic [DATA_WIDTH-1:0]   ir_reg;
  logic [DATA_WIDTH-1:0]   mar_reg;
  logic [DATA_WIDTH-1:0]   mdr_reg;
  logic [DATA_WIDTH-1:0]   y_reg;
  logic [2*DATA_WIDTH-1:0] z_reg;
  logic [DATA_WIDTH-1:0]   hi_reg;
  logic [DATA_WIDTH-1:0]   lo_reg;
  logic                    con_reg;
  logic [DATA_WIDTH-1:0]   inport_reg;
  logic [DATA_WIDTH-1:0]   outport_reg;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0]   bus;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic [DATA_WIDTH-1:0]   c_sext;
  logic [3:0]              ra;
  logic [3:0]              rb;
  logic [3:0]              rc;
  logic [3:0]              index;
  logic [1:0]              c2;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    unused_bits;

  // IR field decode and register-select encoding.
  assign ra     = ir_reg[IR_RA_LSB +: 4];
  assign rb     = ir_reg[IR_RB_LSB +: 4];
  assign rc     = ir_reg[IR_RC_LSB +: 4];
  assign c2     = ir_reg[IR_C2_LSB +: 2];
  assign c_sext = {{(DATA_WIDTH-IR_C_MSB-1){ir_reg[IR_C_MSB]}}, ir_reg[IR_C_MSB:0]};
  assign index  = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);

  assign mem_addr    = mar_reg[ADDR_WIDTH-1:0];
  assign unused_bits = ^{ir_reg[DATA_WIDTH-1:IR_OP_LSB], mar_reg[DATA_WIDTH-1:ADDR_WIDTH]};

  // Fixed-priority bus mux; BAout reads R0 as zero for base-address use.
  always_comb begin
    bus = '0;
    if (Rout || BAout) begin
      if (BAout && !Rout && index == 4'd0) bus = '0;
      else                                 bus = rf_reg[index];
    end
    else if (HIout)      bus = hi_reg;
    else if (LOout)      bus = lo_reg;
    else if (Zhi_out)    bus = z_reg[2*DATA_WIDTH-1:DATA_WIDTH];
    else if (Zlo_out)    bus = z_reg[DATA_WIDTH-1:0];
    else if (PCout)      bus = pc_reg;
    else if (MDRout)     bus = mdr_reg;
    else if (Inport_out) bus = inport_reg;
    else if (Cout)       bus = c_sext;
  end

  system_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (y_reg),
    .b      (bus),
    .opcode (opcode),
    .inc_pc (IncPC),
    .result (alu_result)
  );

  assign mem_rd_data = (Mem_enable512x32 && Mem_Read) ? mem[mem_addr] : '0;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) rf_reg[i] <= '0;
    end else if (Rin) begin
      rf_reg[index] <= bus;
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      mar_reg     <= '0;
      mdr_reg     <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      con_reg     <= 1'b0;
      inport_reg  <= '0;
      outport_reg <= '0;
    end else begin
      if (PCin)              pc_reg      <= bus;
      if (IRin)              ir_reg      <= bus;
      if (MARin)             mar_reg     <= bus;
      if (MDRin)             mdr_reg     <= Mem_Read ? mem_rd_data : bus;
      if (Yin)               y_reg       <= bus;
      if (Zin)               z_reg       <= alu_result;
      if (HIin)              hi_reg      <= bus;
      if (LOin)              lo_reg      <= bus;
      if (CONin)             con_reg     <= con_eval(c2, bus);
      if (inport_data_ready) inport_reg  <= inport_data;
      if (outport_in)        outport_reg <= bus;
    end
  end

  // Memory contents survive clear; the preload port wins over a normal write.
  always_ff @(posedge Clock) begin
    if (mem_overide) begin
      mem[overide_address] <= overide_data_in;
    end else if (Mem_enable512x32 && Mem_Write) begin
      mem[mem_addr] <= mdr_reg;
    end
  end

  assign outport_data         = outport_reg;
  assign con_ff_bit           = con_reg;
  assign Mem_to_datapath_out  = mem_rd_data;
  assign Mem_data_to_chip_out = mdr_reg;
  assign MAR_address_out      = mem_addr;
  assign memory_done          = Mem_enable512x32 && (Mem_Read || Mem_Write);

endmodule

// File: tb/tb_system.sv
// Scoreboard bench for the single-bus datapath: expected values are queued as
// stimulus is applied and compared in order once the DUT produces its result.
module tb_system;

  logic        Clock, clear;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  opcode;
  logic        IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
  logic        mem_overide;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;
  logic [31:0] inport_data;
  logic        inport_data_ready, outport_in;
  logic [31:0] outport_data;
  logic        con_ff_bit;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [8:0]  MAR_address_out;
  logic        memory_done;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  system dut (
    .Clock(Clock), .clear(clear),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .opcode(opcode), .IncPC(IncPC),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .mem_overide(mem_overide), .overide_address(overide_address),
    .overide_data_in(overide_data_in),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_in(outport_in), .outport_data(outport_data), .con_ff_bit(con_ff_bit),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .memory_done(memory_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic idle();
    {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    opcode = 5'd0; IncPC = 1'b0;
    {Mem_Read, Mem_Write, Mem_enable512x32} = '0;
    mem_overide = 1'b0; overide_address = '0; overide_data_in = '0;
    inport_data_ready = 1'b0; outport_in = 1'b0;
  endtask

  // Advance one rising edge; the bench always drives and samples 1 ns after it.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_inport(input logic [31:0] v);
    inport_data = v; inport_data_ready = 1'b1;
    tick();
  endtask

  task automatic fetch();
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1;
    tick();
    Zlo_out = 1; PCin = 1; Mem_Read = 1; Mem_enable512x32 = 1; MDRin = 1;
    tick();
    MDRout = 1; IRin = 1;
    tick();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic inc, input logic [31:0] a, input logic [31:0] b);
    load_inport(a);
    Inport_out = 1; Yin = 1;
    tick();
    load_inport(b);
    Inport_out = 1; opcode = op; IncPC = inc; Zin = 1;
    tick();
  endtask

  task automatic test_reset();
    logic [63:0] got[$];
    logic [31:0] rf_or;
    exp_t e;
    rf_or = '0;
    for (int i = 0; i < 16; i++) rf_or |= dut.rf_reg[i];
    sb_q.push_back('{"rst_pc", 64'h0});        got.push_back(64'(dut.pc_reg));
    sb_q.push_back('{"rst_ir", 64'h0});        got.push_back(64'(dut.ir_reg));
    sb_q.push_back('{"rst_z", 64'h0});         got.push_back(dut.z_reg);
    sb_q.push_back('{"rst_hi_lo_y", 64'h0});   got.push_back(64'(dut.hi_reg | dut.lo_reg | dut.y_reg));
    sb_q.push_back('{"rst_rf", 64'h0});        got.push_back(64'(rf_or));
    sb_q.push_back('{"rst_outport", 64'h0});   got.push_back(64'(outport_data));
    sb_q.push_back('{"rst_con", 64'h0});       got.push_back(64'(con_ff_bit));
    sb_q.push_back('{"rst_mdr_out", 64'h0});   got.push_back(64'(Mem_data_to_chip_out));
    sb_q.push_back('{"rst_mar_out", 64'h0});   got.push_back(64'(MAR_address_out));
    sb_q.push_back('{"rst_mem_done", 64'h0});  got.push_back(64'(memory_done));
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
    end
  endtask

  task automatic test_preload();
    logic [31:0] words[3];
    exp_t e;
    words = '{32'h087FFFFF, 32'h1B000000, 32'h5B800000};
    for (int i = 0; i < 3; i++) begin
      mem_overide = 1; overide_address = 9'(i); overide_data_in = words[i];
      sb_q.push_back('{$sformatf("preload_mem%0d", i), 64'(words[i])});
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front(); checks++;
      if (64'(dut.mem[i]) !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, dut.mem[i], e.exp); failures++;
      end
      $display("preload mem[%0d]=%h", i, dut.mem[i]);
    end
  endtask

  task automatic test_instr0();
    logic [63:0] got[$];
    exp_t e;
    sb_q.push_back('{"i0_ir", 64'h087FFFFF});
    sb_q.push_back('{"i0_y", 64'h0});
    sb_q.push_back('{"i0_z", 64'h00000000FFFFFFFF});
    sb_q.push_back('{"i0_hi", 64'hFFFFFFFF});
    sb_q.push_back('{"i0_lo", 64'hFFFFFFFF});
    sb_q.push_back('{"i0_pc", 64'h1});
    fetch();
    got.push_back(64'(dut.ir_reg));
    Grb = 1; BAout = 1; Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    Cout = 1; opcode = 5'b00011; Zin = 1;
    tick();
    got.push_back(dut.z_reg);
    Zlo_out = 1; HIin = 1; LOin = 1;
    tick();
    got.push_back(64'(dut.hi_reg));
    got.push_back(64'(dut.lo_reg));
    got.push_back(64'(dut.pc_reg));
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
    end
    $display("instr0 hi=%h lo=%h pc=%0d", dut.hi_reg, dut.lo_reg, dut.pc_reg);
  endtask

  task automatic test_mfhi_mflo();
    logic [63:0] got[$];
    exp_t e;
    sb_q.push_back('{"mfhi_r6", 64'hFFFFFFFF});
    sb_q.push_back('{"mfhi_pc", 64'h2});
    sb_q.push_back('{"mflo_r7", 64'hFFFFFFFF});
    sb_q.push_back('{"mflo_pc", 64'h3});
    sb_q.push_back('{"mflo_ir", 64'h5B800000});
    fetch();
    Gra = 1; HIout = 1; Rin = 1;
    tick();
    got.push_back(64'(dut.rf_reg[6]));
    got.push_back(64'(dut.pc_reg));
    fetch();
    Gra = 1; LOout = 1; Rin = 1;
    tick();
    got.push_back(64'(dut.rf_reg[7]));
    got.push_back(64'(dut.pc_reg));
    got.push_back(64'(dut.ir_reg));
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
    end
    $display("mfhi/mflo r6=%h r7=%h pc=%0d", dut.rf_reg[6], dut.rf_reg[7], dut.pc_reg);
  endtask

  task automatic test_mul_div();
    logic [63:0] got[$];
    exp_t e;
    sb_q.push_back('{"mul_z", 64'hFFFFFFFF_FFFFFFFA});
    alu_run(5'b01110, 1'b0, 32'hFFFFFFFE, 32'd3);
    got.push_back(dut.z_reg);
    sb_q.push_back('{"mul_zhi_out", 64'hFFFFFFFF});
    Zhi_out = 1; outport_in = 1;
    tick();
    got.push_back(64'(outport_data));
    sb_q.push_back('{"mul_zlo_out", 64'hFFFFFFFA});
    Zlo_out = 1; outport_in = 1;
    tick();
    got.push_back(64'(outport_data));
    sb_q.push_back('{"div_7_2", 64'h00000001_00000003});
    alu_run(5'b01111, 1'b0, 32'd7, 32'd2);
    got.push_back(dut.z_reg);
    sb_q.push_back('{"div_neg7_2", 64'hFFFFFFFF_FFFFFFFD});
    alu_run(5'b01111, 1'b0, 32'hFFFFFFF9, 32'd2);
    got.push_back(dut.z_reg);
    sb_q.push_back('{"div_by_0", 64'h0});
    alu_run(5'b01111, 1'b0, 32'd9, 32'd0);
    got.push_back(dut.z_reg);
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
      $display("muldiv %s z=%h", e.name, got[i]);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } alu_vec_t;

  task automatic test_alu_ops();
    alu_vec_t v[$];
    exp_t e;
    logic [63:0] got;
    v.push_back('{"add",      5'b00011, 1'b0, 32'd5,        32'd7,        64'd12});
    v.push_back('{"sub",      5'b00100, 1'b0, 32'd3,        32'd5,        64'h00000000_FFFFFFFE});
    v.push_back('{"shr",      5'b00101, 1'b0, 32'h80000000, 32'd4,        64'h08000000});
    v.push_back('{"shra",     5'b00110, 1'b0, 32'h80000000, 32'd4,        64'hF8000000});
    v.push_back('{"shl_b40",  5'b00111, 1'b0, 32'd3,        32'h21,       64'd6});
    v.push_back('{"ror",      5'b01000, 1'b0, 32'd1,        32'd1,        64'h80000000});
    v.push_back('{"ror0",     5'b01000, 1'b0, 32'hDEADBEEF, 32'd0,        64'hDEADBEEF});
    v.push_back('{"rol",      5'b01001, 1'b0, 32'h80000001, 32'd4,        64'h00000018});
    v.push_back('{"and",      5'b01010, 1'b0, 32'hF0F0,     32'hFF00,     64'hF000});
    v.push_back('{"or",       5'b01011, 1'b0, 32'hF0F0,     32'h0F0F,     64'hFFFF});
    v.push_back('{"neg",      5'b10000, 1'b0, 32'd9,        32'd5,        64'hFFFFFFFB});
    v.push_back('{"not",      5'b10001, 1'b0, 32'd9,        32'h0000FFFF, 64'hFFFF0000});
    v.push_back('{"pass_b",   5'b00000, 1'b0, 32'd1,        32'h12345678, 64'h12345678});
    v.push_back('{"incpc",    5'b00011, 1'b1, 32'd100,      32'd41,       64'd42});
    v.push_back('{"incpc_wrap", 5'b00011, 1'b1, 32'd100,    32'hFFFFFFFF, 64'h0});
    foreach (v[i]) begin
      sb_q.push_back('{v[i].name, v[i].exp});
      alu_run(v[i].op, v[i].inc, v[i].a, v[i].b);
      got = dut.z_reg;
      e = sb_q.pop_front(); checks++;
      if (got !== e.exp) begin
        $display("FAIL alu_%s got=%h exp=%h", e.name, got, e.exp); failures++;
      end
      $display("alu %s a=%h b=%h z=%h", v[i].name, v[i].a, v[i].b, got);
    end
  endtask

  task automatic test_bus_select();
    logic [63:0] got[$];
    exp_t e;
    sb_q.push_back('{"prio_hi_over_inport", 64'hFFFFFFFF});
    load_inport(32'h55);
    HIout = 1; Inport_out = 1; Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    sb_q.push_back('{"no_driver", 64'h0});
    Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    load_inport(32'h0003FFFF);
    Inport_out = 1; IRin = 1;
    tick();
    load_inport(32'hABCD);
    Gra = 1; Inport_out = 1; Rin = 1;
    tick();
    sb_q.push_back('{"r0_write", 64'hABCD});
    got.push_back(64'(dut.rf_reg[0]));
    sb_q.push_back('{"baout_r0", 64'h0});
    Gra = 1; BAout = 1; Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    sb_q.push_back('{"rout_r0", 64'hABCD});
    Gra = 1; Rout = 1; Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    sb_q.push_back('{"cout_pos", 64'h0003FFFF});
    Cout = 1; Yin = 1;
    tick();
    got.push_back(64'(dut.y_reg));
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
      $display("bus %s value=%h", e.name, got[i]);
    end
  endtask

  task automatic test_con();
    logic [1:0]  c2s[8];
    logic [31:0] vals[8];
    logic        exps[8];
    exp_t e;
    c2s  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    vals = '{32'd0, 32'd5, 32'd5, 32'd0, 32'd0, 32'h80000000, 32'h80000000, 32'd1};
    exps = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      load_inport({11'b0, c2s[i], 19'b0});
      Inport_out = 1; IRin = 1;
      tick();
      load_inport(vals[i]);
      sb_q.push_back('{$sformatf("con_c2_%0d_%h", c2s[i], vals[i]), 64'(exps[i])});
      Inport_out = 1; CONin = 1;
      tick();
      e = sb_q.pop_front(); checks++;
      if (64'(con_ff_bit) !== e.exp) begin
        $display("FAIL %s got=%b exp=%b", e.name, con_ff_bit, e.exp[0]); failures++;
      end
      $display("con c2=%0d bus=%h con=%b", c2s[i], vals[i], con_ff_bit);
    end
  endtask

  task automatic test_memory();
    logic [63:0] got[$];
    exp_t e;
    load_inport(32'h00010105);
    Inport_out = 1; MARin = 1;
    tick();
    sb_q.push_back('{"mar_out", 64'h105});
    got.push_back(64'(MAR_address_out));
    load_inport(32'hCAFEF00D);
    Inport_out = 1; MDRin = 1;
    tick();
    sb_q.push_back('{"mdr_out", 64'hCAFEF00D});
    got.push_back(64'(Mem_data_to_chip_out));
    Mem_Write = 1; Mem_enable512x32 = 1;
    #1;
    sb_q.push_back('{"done_write", 64'h1});
    got.push_back(64'(memory_done));
    tick();
    sb_q.push_back('{"mem_write", 64'hCAFEF00D});
    got.push_back(64'(dut.mem[9'h105]));
    Mem_Read = 1;
    #1;
    sb_q.push_back('{"read_no_enable", 64'h0});
    got.push_back(64'(Mem_to_datapath_out));
    Mem_enable512x32 = 1;
    #1;
    sb_q.push_back('{"read_comb", 64'hCAFEF00D});
    got.push_back(64'(Mem_to_datapath_out));
    tick();
    load_inport(32'h11111111);
    Inport_out = 1; MDRin = 1;
    tick();
    load_inport(32'h44444444);
    Inport_out = 1; MDRin = 1; Mem_Read = 1; Mem_enable512x32 = 1;
    tick();
    sb_q.push_back('{"mdr_from_mem", 64'hCAFEF00D});
    got.push_back(64'(Mem_data_to_chip_out));
    load_inport(32'h33333333);
    Inport_out = 1; MDRin = 1;
    tick();
    Mem_Write = 1;
    tick();
    sb_q.push_back('{"write_needs_enable", 64'hCAFEF00D});
    got.push_back(64'(dut.mem[9'h105]));
    mem_overide = 1; overide_address = 9'h010; overide_data_in = 32'h22222222;
    Mem_Write = 1; Mem_enable512x32 = 1;
    tick();
    sb_q.push_back('{"overide_blocks_write", 64'hCAFEF00D});
    got.push_back(64'(dut.mem[9'h105]));
    sb_q.push_back('{"overide_write", 64'h22222222});
    got.push_back(64'(dut.mem[9'h010]));
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
      $display("memory %s value=%h", e.name, got[i]);
    end
  endtask

  task automatic test_clear_mid();
    logic [63:0] got[$];
    logic [31:0] rf_or;
    logic [31:0] words[3];
    exp_t e;
    words = '{32'h087FFFFF, 32'h1B000000, 32'h5B800000};
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1;
    tick();
    Zlo_out = 1; PCin = 1; Mem_Read = 1; Mem_enable512x32 = 1; MDRin = 1;
    tick();
    MDRout = 1; IRin = 1;
    #1;
    clear = 1'b0;
    #1;
    rf_or = '0;
    for (int i = 0; i < 16; i++) rf_or |= dut.rf_reg[i];
    sb_q.push_back('{"clr_pc", 64'h0}); got.push_back(64'(dut.pc_reg));
    sb_q.push_back('{"clr_ir", 64'h0}); got.push_back(64'(dut.ir_reg));
    sb_q.push_back('{"clr_rf", 64'h0}); got.push_back(64'(rf_or));
    sb_q.push_back('{"clr_z", 64'h0});  got.push_back(dut.z_reg);
    sb_q.push_back('{"clr_outport", 64'h0}); got.push_back(64'(outport_data));
    idle();
    #1;
    clear = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{$sformatf("clr_mem%0d", i), 64'(words[i])});
      got.push_back(64'(dut.mem[i]));
    end
    for (int i = 0; i < got.size(); i++) begin
      e = sb_q.pop_front(); checks++;
      if (got[i] !== e.exp) begin
        $display("FAIL %s got=%h exp=%h", e.name, got[i], e.exp); failures++;
      end
      $display("clear %s value=%h", e.name, got[i]);
    end
  endtask

  initial begin
    idle();
    inport_data = '0;
    clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    clear = 1'b1;
    test_preload();
    test_instr0();
    test_mfhi_mflo();
    test_mul_div();
    test_alu_ops();
    test_bus_select();
    test_con();
    test_memory();
    test_clear_mid();
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
      failures++;
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit reached");
  end

endmodule
